unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Sequences the single-port unified instruction/data memory between two requesters: instruction fetch (IF) and the load/store stage (MEM).
- Replaces clock-phase address muxing with an explicit request/valid handshake, per-port stall outputs and a bounded-starvation priority scheme.
- Sits between the fetch/MEM pipeline stages and the memory block; one access outstanding at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from issue cycle to valid mem_rdata; legal 1..7.
- STARVE_MAX, 4, max consecutive data grants while if_req is pending; legal 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request (level, held until if_valid).
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word (registered).
- if_valid  out  1  one-cycle completion pulse.
- if_stall  out  1  fetch must hold.
- d_req  in  1  data request (level, held until d_valid).
- d_we  in  1  1 = store.
- d_mode  in  3  funct3 size/sign mode.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data (registered).
- d_valid  out  1  one-cycle completion pulse.
- d_stall  out  1  MEM stage must hold.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_mode  out  3  memory size mode.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: all outputs 0, if_rdata/d_rdata 0, state IDLE, starve count 0, latency count 0.
- Reset mid-access abandons the outstanding access and produces no valid pulse.
- FSM states and transitions:
  - IDLE: arbitrate among sampled requests. On a grant, go to ISSUE and register the mem_* fields at the next edge.
  - ISSUE: hold for exactly one cycle with mem_en=1, then go to WAIT.
  - WAIT: count MEM_LAT cycles, beginning at the issue cycle. Capture mem_rdata in cycle issue+MEM_LAT, then go to DONE.
  - DONE: for one cycle, drive the granted port's valid=1 and present the captured data on its rdata, then go to IDLE.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr/mem_wdata/mem_mode hold their last values.
- Fetch access fields: mem_we=0, mem_mode=3'b010 (word), mem_addr=if_addr.
- Data access fields: mem_we=d_we, mem_mode=d_mode, mem_addr=d_addr, mem_wdata=d_wdata.
- Latency: request sampled in IDLE at cycle t, issue at t+1, valid at t+MEM_LAT+2. Throughput is one access per MEM_LAT+3 cycles.
- Stores also pulse d_valid; d_rdata is unchanged by a store.
- rdata registers hold their value until that port's next load/fetch completion.
- Priority:
  - d_req wins over if_req.
  - Exception: when starve_cnt==STARVE_MAX and if_req=1, IF is granted.
  - starve_cnt increments on a data grant while if_req=1 (saturates at STARVE_MAX).
  - starve_cnt clears on an IF grant, or in IDLE when if_req=0.
- Both requests in IDLE with starve_cnt<STARVE_MAX: data is granted; IF waits.
- Requests are only sampled in IDLE. A requester still asserting req in its DONE cycle is judged in the following IDLE cycle as a new request.
- Stall outputs (combinational): if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid.
- Request fields must stay stable while req=1 and before valid. They are sampled at the grant edge only; later changes are ignored for that access.
- Address alignment is not checked; the address passes through unchanged.

Decomposition:
- Shared package (mem_arb_pkg):
  - state enum {IDLE, ISSUE, WAIT, DONE}.
  - grant source enum {GNT_IF, GNT_D}.
  - MODE_WORD = 3'b010.
  - Latency counter width 3, starve counter width 4.
- One sub-module: mem_arb_prio.
  - Inputs: if_req, d_req, starve_cnt.
  - Outputs: grant valid, grant source.
  - Purely combinational; contains the starvation rule.
- FSM, counters and registers live in unified_mem_arbiter.

Test Plan:
- Reset, then single fetch, MEM_LAT=1: if_req=1, if_addr=0x10, mem_rdata=0x00500093 → mem_en pulse in cycle 2 with mem_addr=0x10, mem_we=0; if_valid in cycle 4 with if_rdata=0x00500093; if_stall=1 in cycles 1–3.
- Simultaneous requests: if_req=1 (0x20) and d_req=1 load (0x100, mode 3'b010) in the same IDLE cycle → data access issues first; fetch issues after d_valid; if_stall stays high throughout.
- Store: d_we=1, d_addr=0x104, d_wdata=0xDEADBEEF, d_mode=3'b000 → one cycle with mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF, mem_mode=0; d_valid pulses; d_rdata keeps its prior value.
- Starvation, STARVE_MAX=4: d_req held high continuously, if_req high → exactly 4 data grants, then 1 IF grant, then data resumes.
- Reset mid-access, MEM_LAT=3: assert rst in a WAIT cycle → next cycle all outputs 0, state IDLE, no valid pulse; a fresh request then completes normally.
- Latency sweep MEM_LAT=1..7: valid occurs exactly MEM_LAT+2 cycles after the request is sampled in IDLE, and exactly one mem_en pulse occurs per access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } gnt_src_e;

    localparam logic [2:0] MODE_WORD    = 3'b010;
    localparam int         LAT_CNT_W    = 3;
    localparam int         STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant selection: data wins unless fetch has been starved
// for STARVE_MAX consecutive data grants.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                    if_req,
    input  logic                    d_req,
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
    output logic                    gnt_valid,
    output gnt_src_e                gnt_src
);

    logic starved;

    always_comb begin
        starved   = if_req && (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
        gnt_valid = if_req | d_req;
        gnt_src   = GNT_IF;
        if (starved) begin
            gnt_src = GNT_IF;
        end else if (d_req) begin
            gnt_src = GNT_D;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Sequences one access at a time from instruction fetch or load/store into a
// single-port memory: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_mode,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e                  state_q, state_d;
    gnt_src_e                src_q, src_d;
    logic [LAT_CNT_W-1:0]    lat_q, lat_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    we_q, we_d;
    logic [2:0]              mode_q, mode_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]       d_rdata_q, d_rdata_d;

    logic                    gnt_valid;
    gnt_src_e                gnt_src;
    logic                    lat_done;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .gnt_valid  (gnt_valid),
        .gnt_src    (gnt_src)
    );

    assign lat_done = (lat_q == LAT_CNT_W'(MEM_LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= GNT_IF;
            lat_q      <= '0;
            starve_q   <= '0;
            we_q       <= 1'b0;
            mode_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (lat_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are latched only at the grant edge; the memory side sees
    // registered values that hold until the next grant.
    always_comb begin
        src_d      = src_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        we_d       = we_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end else if (gnt_valid && gnt_src == GNT_IF) begin
                    starve_d = '0;
                end else if (gnt_valid && starve_q < STARVE_CNT_W'(STARVE_MAX)) begin
                    starve_d = starve_q + STARVE_CNT_W'(1);
                end
                if (gnt_valid) begin
                    src_d = gnt_src;
                    if (gnt_src == GNT_D) begin
                        we_d    = d_we;
                        mode_d  = d_mode;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d   = 1'b0;
                        mode_d = MODE_WORD;
                        addr_d = if_addr;
                    end
                end
            end
            // The issue cycle counts as latency cycle 0, so WAIT sees 1..MEM_LAT.
            ISSUE: lat_d = LAT_CNT_W'(1);
            WAIT: begin
                lat_d = lat_q + LAT_CNT_W'(1);
                if (lat_done && !we_q) begin
                    if (src_q == GNT_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_en    = (state_q == ISSUE);
        mem_we    = mem_en & we_q;
        mem_mode  = mode_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_valid  = (state_q == DONE) && (src_q == GNT_IF);
        d_valid   = (state_q == DONE) && (src_q == GNT_D);
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        if_stall  = if_req & ~if_valid;
        d_stall   = d_req & ~d_valid;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: seven instances with MEM_LAT 1..7, each fed by
// a latency-exact memory model; instance 0 carries a scoreboarded directed run.
module tb_unified_mem_arbiter;

    localparam int N = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]       if_req, d_req, d_we;
    logic [N-1:0]       if_valid, if_stall, d_valid, d_stall, mem_en, mem_we;
    logic [N-1:0][31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [N-1:0][2:0]  d_mode, mem_mode;

    int tests = 0;
    int fails = 0;

    logic [35:0] iss_q[$];
    logic [31:0] iss_wd_q[$];
    logic [31:0] if_exp_q[$];
    logic [31:0] d_exp_q[$];

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : ((a ^ 32'hA5A5_0000) + 32'h0000_1234);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            int          pend_cnt;
            logic [31:0] pend_addr;
            logic [31:0] rd;

            unified_mem_arbiter #(
                .ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .STARVE_MAX(4)
            ) dut (
                .clk(clk), .rst(rst),
                .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]),
                .if_valid(if_valid[g]), .if_stall(if_stall[g]),
                .d_req(d_req[g]), .d_we(d_we[g]), .d_mode(d_mode[g]), .d_addr(d_addr[g]),
                .d_wdata(d_wdata[g]), .d_rdata(d_rdata[g]), .d_valid(d_valid[g]),
                .d_stall(d_stall[g]),
                .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_mode(mem_mode[g]),
                .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(rd)
            );

            // Read data is only correct in cycle issue+LAT; garbage otherwise.
            always @(posedge clk) begin
                if (rst) pend_cnt <= 0;
                else if (mem_en[g]) begin
                    pend_cnt  <= 1;
                    pend_addr <= mem_addr[g];
                end else if (pend_cnt != 0 && pend_cnt < g + 1) pend_cnt <= pend_cnt + 1;
                else pend_cnt <= 0;
            end
            assign rd = (pend_cnt == g + 1) ? memval(pend_addr) : 32'hBAD0_BAD0;
        end
    endgenerate

    // Scoreboard for instance 0: issue fields in order, completions by port.
    always @(negedge clk) begin
        logic [35:0] e;
        logic [31:0] w;
        if (!rst) begin
            if (mem_en[0]) begin
                if (iss_q.size() == 0) check("iss_extra", {63'd0, mem_en[0]}, 64'd0);
                else begin
                    e = iss_q.pop_front();
                    w = iss_wd_q.pop_front();
                    check("iss_fields", {28'd0, mem_we[0], mem_mode[0], mem_addr[0]}, {28'd0, e});
                    if (e[35]) check("iss_wdata", {32'd0, mem_wdata[0]}, {32'd0, w});
                end
            end else check("we_outside_issue", {63'd0, mem_we[0]}, 64'd0);
            if (if_valid[0]) begin
                if (if_exp_q.size() == 0) check("if_extra", {63'd0, if_valid[0]}, 64'd0);
                else check("if_rdata", {32'd0, if_rdata[0]}, {32'd0, if_exp_q.pop_front()});
            end
            if (d_valid[0]) begin
                if (d_exp_q.size() == 0) check("d_extra", {63'd0, d_valid[0]}, 64'd0);
                else check("d_rdata", {32'd0, d_rdata[0]}, {32'd0, d_exp_q.pop_front()});
            end
            check("if_stall", {63'd0, if_stall[0]}, {63'd0, if_req[0] & ~if_valid[0]});
            check("d_stall", {63'd0, d_stall[0]}, {63'd0, d_req[0] & ~d_valid[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drops each request the cycle after its valid; returns cycles and issue count.
    task automatic run(input int k, output int ncyc, output int nen);
        logic vi, vd;
        ncyc = 0;
        nen  = 0;
        while ((if_req[k] || d_req[k]) && ncyc < 80) begin
            @(negedge clk);
            ncyc++;
            if (mem_en[k]) nen++;
            vi = if_valid[k];
            vd = d_valid[k];
            tick();
            if (vi) if_req[k] = 1'b0;
            if (vd) d_req[k] = 1'b0;
        end
        check("run_timeout", {63'd0, ncyc < 80}, 64'd1);
    endtask

    initial begin
        int n, en, dcnt;
        logic vi, vd;
        logic [31:0] a;
        if_req = '0; d_req = '0; d_we = '0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_mode = '0;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_en", {63'd0, mem_en[0]}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr[0]}, 64'd0);
        check("rst_if_rdata", {32'd0, if_rdata[0]}, 64'd0);
        check("rst_valids", {62'd0, if_valid[6], d_valid[6]}, 64'd0);

        // Single fetch, MEM_LAT=1: issue in cycle 2, valid in cycle 4.
        tick();
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        iss_q.push_back({1'b0, 3'b010, 32'h10}); iss_wd_q.push_back('0);
        if_exp_q.push_back(32'h0050_0093);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t1_stall", {63'd0, if_stall[0]}, {63'd0, c <= 3});
            check("t1_mem_en", {63'd0, mem_en[0]}, {63'd0, c == 2});
            check("t1_if_valid", {63'd0, if_valid[0]}, {63'd0, c == 4});
            if (c < 4) tick();
        end
        tick();
        if_req[0] = 1'b0;

        // Simultaneous requests: data first, then fetch; two back-to-back accesses.
        tick();
        if_req[0] = 1'b1; if_addr[0] = 32'h20;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_mode[0] = 3'b010; d_addr[0] = 32'h100;
        iss_q.push_back({1'b0, 3'b010, 32'h100}); iss_wd_q.push_back('0);
        iss_q.push_back({1'b0, 3'b010, 32'h20});  iss_wd_q.push_back('0);
        d_exp_q.push_back(memval(32'h100));
        if_exp_q.push_back(memval(32'h20));
        run(0, n, en);
        check("t2_cycles", n, 8);
        check("t2_issues", en, 2);

        // Store: d_rdata keeps the previous load value.
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_mode[0] = 3'b000;
        d_addr[0] = 32'h104; d_wdata[0] = 32'hDEAD_BEEF;
        iss_q.push_back({1'b1, 3'b000, 32'h104}); iss_wd_q.push_back(32'hDEAD_BEEF);
        d_exp_q.push_back(memval(32'h100));
        run(0, n, en);
        check("t3_cycles", n, 4);
        d_we[0] = 1'b0;

        // Starvation: four data grants, one fetch, then data again.
        tick();
        if_req[0] = 1'b1; if_addr[0] = 32'h30;
        d_req[0] = 1'b1; d_mode[0] = 3'b010; d_addr[0] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            iss_q.push_back({1'b0, 3'b010, 32'h200}); iss_wd_q.push_back('0);
        end
        iss_q.push_back({1'b0, 3'b010, 32'h30});  iss_wd_q.push_back('0);
        iss_q.push_back({1'b0, 3'b010, 32'h200}); iss_wd_q.push_back('0);
        for (int i = 0; i < 5; i++) d_exp_q.push_back(memval(32'h200));
        if_exp_q.push_back(memval(32'h30));
        n = 0; dcnt = 0;
        while ((if_req[0] || d_req[0]) && n < 100) begin
            @(negedge clk);
            n++;
            vi = if_valid[0];
            vd = d_valid[0];
            tick();
            if (vi) if_req[0] = 1'b0;
            if (vd) begin
                dcnt++;
                if (dcnt == 5) d_req[0] = 1'b0;
            end
        end
        check("t4_cycles", n, 24);
        check("t4_iss_left", iss_q.size(), 0);

        // Reset during WAIT on the MEM_LAT=3 instance.
        tick();
        if_req[2] = 1'b1; if_addr[2] = 32'h40;
        tick();
        tick();
        rst = 1'b1; if_req[2] = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rr_mem", {26'd0, mem_en[2], mem_we[2], mem_mode[2], 32'd0}, 64'd0);
        check("rr_addr", {mem_addr[2], mem_wdata[2]}, 64'd0);
        check("rr_rdata", {if_rdata[2], d_rdata[2]}, 64'd0);
        check("rr_flags", {60'd0, if_valid[2], d_valid[2], if_stall[2], d_stall[2]}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            check("rr_no_valid", {62'd0, if_valid[2], mem_en[2]}, 64'd0);
        end

        // Latency sweep: valid MEM_LAT+2 cycles after sampling, one issue each.
        for (int k = 0; k < N; k++) begin
            tick();
            a = 32'h1000 + 32'(k * 16);
            if_req[k] = 1'b1; if_addr[k] = a;
            if (k == 0) begin
                iss_q.push_back({1'b0, 3'b010, a}); iss_wd_q.push_back('0);
                if_exp_q.push_back(memval(a));
            end
            run(k, n, en);
            check("lat_cycles", n, k + 4);
            check("lat_issues", en, 1);
            check("lat_rdata", {32'd0, if_rdata[k]}, {32'd0, memval(a)});
        end

        tick();
        check("sb_empty", iss_q.size() + if_exp_q.size() + d_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
